// File: rtl/oam_dma.sv
// oam_dma: sprite-DMA initiator for the $4014 port.
// A CPU write to TRIGGER_ADDR halts the CPU. The block then copies XFER_LEN bytes
// from page {bus_din,8'h00} to DEST_ADDR, acting as bus initiator.
// Optional feature macro: OAM_DMA_PROGRESS_EN (adds the dma_count output).
// Ports:
//   cpu_clk, reset      clock; synchronous active-low reset
//   bus_addr/din/wr     CPU bus, watched for the trigger write
//   odd_or_even         CPU cycle parity (1 = odd), checked in HALT
//   rd_data             bus read data, sampled at the end of each READ
//   dma_hijack          CPU halted / bus owned by DMA
//   dma_addr/dout/wr    DMA bus address, write data and write strobe
//   dma_done            one-cycle pulse after the last write
//   dma_count           (optional) number of bytes written in this transfer
module oam_dma #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR    = 16'h2004,
   parameter int unsigned XFER_LEN     = 256
) (
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_din,
   input  logic        bus_wr,
   input  logic        odd_or_even,
   input  logic [7:0]  rd_data,
   output logic        dma_hijack,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_dout,
   output logic        dma_wr,
`ifdef OAM_DMA_PROGRESS_EN
   output logic [8:0]  dma_count,
`endif
   output logic        dma_done
);

   localparam int unsigned IDX_W = 9;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [7:0]       page_q, page_d;
   logic             hijack_q, hijack_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       dout_q, dout_d;
   logic             wr_q, wr_d;
   logic             done_q, done_d;
   logic             trig_c;

   // Trigger is only honoured while idle
   assign trig_c = (state_q == S_IDLE) && bus_wr && (bus_addr == TRIGGER_ADDR);

   // Next-state logic; outputs are registered from the next state so they line up
   // with the state they describe
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      page_d  = page_q;
      addr_d  = addr_q;
      dout_d  = dout_q;

      case (state_q)
         S_IDLE: begin
            if (trig_c) begin
               page_d  = bus_din;
               index_d = '0;
               state_d = S_HALT;
            end
         end
         S_HALT:  state_d = odd_or_even ? S_ALIGN : S_READ;
         S_ALIGN: state_d = S_READ;
         S_READ: begin
            // dout register doubles as the read buffer
            dout_d  = rd_data;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (index_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               index_d = index_q + IDX_W'(1);
               state_d = S_READ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Source address never carries past the page: only index[7:0] is used
      if (state_d == S_READ) begin
         addr_d = {page_d, index_d[7:0]};
      end else if (state_d == S_WRITE) begin
         addr_d = DEST_ADDR;
      end

      hijack_d = (state_d == S_HALT) || (state_d == S_ALIGN) ||
                 (state_d == S_READ) || (state_d == S_WRITE);
      wr_d     = (state_d == S_WRITE);
      done_d   = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge cpu_clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         page_q   <= '0;
         hijack_q <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         wr_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         page_q   <= page_d;
         hijack_q <= hijack_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         wr_q     <= wr_d;
         done_q   <= done_d;
      end
   end

   assign dma_hijack = hijack_q;
   assign dma_addr   = addr_q;
   assign dma_dout   = dout_q;
   assign dma_wr     = wr_q;
   assign dma_done   = done_q;

`ifdef OAM_DMA_PROGRESS_EN
   logic [8:0] count_q, count_d;

   // Counts completed writes; cleared by a new trigger, held otherwise
   always_comb begin
      count_d = count_q;
      if (trig_c) begin
         count_d = '0;
      end else if (state_q == S_WRITE) begin
         count_d = count_q + 9'd1;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign dma_count = count_q;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with an address/data scoreboard.
module tb_oam_dma;

   localparam int unsigned XFER = 256;
   localparam logic [15:0] DEST = 16'h2004;

   logic        clk;
   logic        reset;
   logic [15:0] bus_addr;
   logic [7:0]  bus_din;
   logic        bus_wr;
   logic        odd_or_even;
   logic [7:0]  rd_data;
   logic        dma_hijack;
   logic [15:0] dma_addr;
   logic [7:0]  dma_dout;
   logic        dma_wr;
   logic        dma_done;
`ifdef OAM_DMA_PROGRESS_EN
   logic [8:0]  dma_count;
`endif

   oam_dma dut (
      .cpu_clk     (clk),
      .reset       (reset),
      .bus_addr    (bus_addr),
      .bus_din     (bus_din),
      .bus_wr      (bus_wr),
      .odd_or_even (odd_or_even),
      .rd_data     (rd_data),
      .dma_hijack  (dma_hijack),
      .dma_addr    (dma_addr),
      .dma_dout    (dma_dout),
      .dma_wr      (dma_wr),
`ifdef OAM_DMA_PROGRESS_EN
      .dma_count   (dma_count),
`endif
      .dma_done    (dma_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   int hij_cnt, wr_cnt, done_cnt, first_wr;
   logic        mode;
   logic [15:0] prev_addr, last_rd;
   logic [7:0]  last_dout;
   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];

   // Bus memory model
   function automatic logic [7:0] data_of(input logic [15:0] a);
      return mode ? ~a[7:0] : (a[7:0] ^ a[15:8] ^ 8'h5A);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample outputs 1 time unit after the edge, answer reads, score writes
   task automatic tick();
      logic [15:0] ea;
      logic [7:0]  ed;
      @(posedge clk);
      #1;
      rd_data = data_of(dma_addr);
      if (dma_hijack) hij_cnt++;
      if (dma_done) done_cnt++;
`ifdef OAM_DMA_PROGRESS_EN
      if (dma_hijack || dma_done) chk("dma_count", 32'(dma_count), 32'(wr_cnt));
`endif
      if (dma_wr) begin
         wr_cnt++;
         if (first_wr == 0) first_wr = hij_cnt;
         chk("wr_in_hijack", 32'(dma_hijack), 32'd1);
         chk("wr_dest", 32'(dma_addr), 32'(DEST));
         if (exp_addr_q.size() == 0) begin
            chk("wr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
         end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            chk("rd_addr", 32'(prev_addr), 32'(ea));
            chk("wr_data", 32'(dma_dout), 32'(ed));
         end
         last_rd   = prev_addr;
         last_dout = dma_dout;
      end
      prev_addr = dma_addr;
   endtask

   task automatic start(input logic [7:0] pg);
      logic [15:0] a;
      hij_cnt = 0; wr_cnt = 0; done_cnt = 0; first_wr = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < int'(XFER); i++) begin
         a = {pg, 8'(i)};
         exp_addr_q.push_back(a);
         exp_data_q.push_back(data_of(a));
      end
      bus_addr = 16'h4014; bus_din = pg; bus_wr = 1'b1;
      tick();
      bus_wr = 1'b0;
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d);
      bus_addr = a; bus_din = d; bus_wr = 1'b1;
   endtask

   // Runs until dma_done is seen, optionally injecting stray CPU writes
   task automatic wait_done(input bit inj);
      for (int i = 0; i < 700 && done_cnt == 0; i++) begin
         if (inj) begin
            case (i)
               10:      drive(16'h4014, 8'h33);
               20:      drive(16'h4015, 8'h44);
               30:      drive(16'h2004, 8'h55);
               default: bus_wr = 1'b0;
            endcase
         end
         tick();
      end
      bus_wr = 1'b0;
      chk("done_seen", 32'(done_cnt), 32'd1);
   endtask

   task automatic finish_xfer(input string tag, input int exp_hij);
      chk({tag, "_hijack_cycles"}, 32'(hij_cnt), 32'(exp_hij));
      chk({tag, "_writes"}, 32'(wr_cnt), 32'(XFER));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_queue_left"}, 32'(exp_addr_q.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b0; bus_addr = '0; bus_din = '0; bus_wr = 1'b0;
      odd_or_even = 1'b0; rd_data = '0; mode = 1'b0;
      prev_addr = '0; last_rd = '0; last_dout = '0;
      hij_cnt = 0; wr_cnt = 0; done_cnt = 0; first_wr = 0;

      // Reset state
      repeat (3) tick();
      chk("rst_hijack", 32'(dma_hijack), 32'd0);
      chk("rst_wr", 32'(dma_wr), 32'd0);
      chk("rst_done", 32'(dma_done), 32'd0);
      chk("rst_addr", 32'(dma_addr), 32'd0);
      chk("rst_dout", 32'(dma_dout), 32'd0);
      reset = 1'b1;
      repeat (2) tick();

      // Even parity: 513 hijack cycles, first write on hijack cycle 3
      odd_or_even = 1'b0;
      start(8'h02);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("even", 513);
      chk("even_first_wr", 32'(first_wr), 32'd3);

      // Odd parity: extra ALIGN cycle
      odd_or_even = 1'b1;
      start(8'h02);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("odd", 514);
      chk("odd_first_wr", 32'(first_wr), 32'd4);

      // Page $FF with inverted-address data
      odd_or_even = 1'b0;
      mode = 1'b1;
      start(8'hFF);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("pgff", 513);
      chk("pgff_last_rd", 32'(last_rd), 32'hFFFF);
      chk("pgff_last_dout", 32'(last_dout), 32'h00);
      mode = 1'b0;

      // Stray writes during hijack leave the page and byte count alone
      start(8'h02);
      wait_done(1'b1);
      repeat (3) tick();
      finish_xfer("stray", 513);
      hij_cnt = 0; wr_cnt = 0;
      drive(16'h4015, 8'h11); tick();
      drive(16'h2004, 8'h22); tick();
      bus_wr = 1'b0;
      repeat (5) tick();
      chk("idle_other_hijack", 32'(hij_cnt), 32'd0);
      chk("idle_other_writes", 32'(wr_cnt), 32'd0);

      // Trigger during DONE is ignored; held into IDLE it is accepted
      start(8'h04);
      wait_done(1'b0);
      finish_xfer("pg04", 513);
      drive(16'h4014, 8'h05);
      tick();
      chk("done_trig_ignored", 32'(dma_hijack), 32'd0);
      start(8'h05);
      chk("idle_trig_taken", 32'(dma_hijack), 32'd1);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("pg05", 513);

      // Reset mid-transfer at byte 100, then a clean restart
      start(8'h03);
      for (int i = 0; i < 600 && wr_cnt < 100; i++) tick();
      chk("pre_reset_writes", 32'(wr_cnt), 32'd100);
      reset = 1'b0;
      tick();
      chk("midrst_hijack", 32'(dma_hijack), 32'd0);
      chk("midrst_wr", 32'(dma_wr), 32'd0);
      chk("midrst_addr", 32'(dma_addr), 32'd0);
      reset = 1'b1;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (20) tick();
      chk("post_rst_writes", 32'(wr_cnt), 32'd100);
      chk("post_rst_hijack", 32'(dma_hijack), 32'd0);
      start(8'h03);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("restart", 513);
`ifdef OAM_DMA_PROGRESS_EN
      chk("count_hold", 32'(dma_count), 32'(XFER));
      start(8'h06);
      chk("count_cleared", 32'(dma_count), 32'd0);
      wait_done(1'b0);
      repeat (3) tick();
      finish_xfer("count", 513);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
